sfifo_flex: RTL
===============

Name: sfifo_flex

Overview:
- Parametrised single-clock FIFO; next generation of the team's basic synchronous FIFO.
- Adds:
  - true DEPTH-word capacity with an exact occupancy count;
  - programmable almost-full and almost-empty thresholds;
  - optional first-word-fall-through (FWFT) read mode;
  - sticky overflow and underflow error flags;
  - synchronous flush.
- Used as the generic buffering stage between datapath blocks in one clock domain.

Parameters:
- WIDTH, 8: data width in bits.
- DEPTH, 16: capacity in words; power of two, at least 4.
- AF_LVL, 12: almost_full asserts when data_cnt >= AF_LVL; valid range 1..DEPTH.
- AE_LVL, 4: almost_empty asserts when data_cnt <= AE_LVL; valid range 0..DEPTH-1.
- FWFT, 0: 0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sclr  in  1  synchronous flush; empties the FIFO and clears the error flags.
- winc  in  1  write request.
- wdata  in  WIDTH  write data.
- rinc  in  1  read request (standard mode) or pop (FWFT mode).
- rdata  out  WIDTH  read data.
- rvalid  out  1  standard mode: rdata is valid this cycle; FWFT mode: equals !rempty.
- wfull  out  1  FIFO holds DEPTH words.
- rempty  out  1  no word available to read.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- data_cnt  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset values: data_cnt=0, rempty=1, wfull=0, almost_empty=1, almost_full=0, rvalid=0, overflow=0, underflow=0, rdata=0. Pointers reset to 0.
- Reset mid-operation: all contents discarded immediately; no partial update on release.
- Accept rules, on the same-cycle flag values:
  - w_acc = winc & !wfull
  - r_acc = rinc & !rempty
- Rejected requests have no effect on contents or count.
- A rejected write sets overflow; a rejected read sets underflow. Both flags hold until rst or sclr.
- data_cnt:
  - +1 on w_acc only; -1 on r_acc only; unchanged when both or neither.
  - Never exceeds DEPTH and never wraps below 0.
- Flags are registered and reflect the post-edge data_cnt in the same cycle data_cnt updates (no extra lag):
  - wfull = (cnt == DEPTH)
  - almost_full = (cnt >= AF_LVL)
  - almost_empty = (cnt <= AE_LVL)
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Full and empty are distinguished by data_cnt, not by the pointers.
- Simultaneous winc & rinc:
  - When full: only the read is accepted; count becomes DEPTH-1, overflow is set.
  - When empty: only the write is accepted; count becomes 1, underflow is set.
  - Otherwise both are accepted; count is unchanged and data order is preserved.
- FWFT=0 (standard mode):
  - rempty = (cnt == 0). Write accepted at edge N → rempty low after edge N.
  - Read accepted at edge M → rdata updates at edge M+1 (available in cycle M+1) with rvalid=1 for exactly that one cycle.
  - rdata holds its last value otherwise.
- FWFT=1 (first-word-fall-through mode):
  - The head word is presented on rdata while rempty=0; rinc pops it.
  - Write into empty FIFO at edge N → rdata=head and rempty=0 after edge N+1 (2-cycle write-to-visible).
  - r_acc at edge M → the next word is on rdata after edge M with no bubble if cnt >= 2.
  - rempty is 0 only when rdata holds valid data. Capacity remains DEPTH words including the presented word.
- sclr:
  - Takes effect at the edge; equivalent to reset for pointers, count, flags, rvalid and error flags.
  - Has priority over winc/rinc in the same cycle. rdata is not cleared.
- Memory: inferred dual-port array, one write port and one read port on clk. No reset on the array.

Test Plan:
- Reset then idle → rempty=1, almost_empty=1, data_cnt=0, wfull=0, overflow=0, underflow=0.
- FWFT=0, DEPTH=16: write 0x00..0x0F → wfull=1 after the 16th edge, almost_full=1 from data_cnt=12; a 17th write is rejected and overflow=1.
- Read all 16 words → rdata 0x00..0x0F in order, one cycle after each accepted read; rempty=1 after the last read; a further rinc sets underflow=1.
- Full FIFO with winc=rinc=1 → data_cnt=15, wfull=0, overflow=1. Empty FIFO with both high → data_cnt=1, underflow=1.
- FWFT=1: write 0xA5 into empty → rdata=0xA5 and rempty=0 two cycles later with no rinc. Write 0x3C, then pulse rinc → rdata=0x3C next cycle.
- Write 5 words, assert sclr together with winc → data_cnt=0, rempty=1, error flags cleared. Assert rst mid-stream → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/sfifo_flex.sv
// sfifo_flex: single-clock FIFO with exact occupancy count, programmable
// almost-full/almost-empty thresholds, optional first-word-fall-through
// read mode, sticky overflow/underflow flags and synchronous flush.
module sfifo_flex #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AF_LVL = 12,
  parameter int unsigned AE_LVL = 4,
  parameter int unsigned FWFT   = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_sclr,
  input  logic                       i_winc,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_rinc,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_rvalid,
  output logic                       o_wfull,
  output logic                       o_rempty,
  output logic                       o_almost_full,
  output logic                       o_almost_empty,
  output logic [$clog2(DEPTH):0]     o_data_cnt,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_mem_q;
  logic [WIDTH-1:0] r_rdata;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             r_wfull;
  logic             r_rempty;
  logic             r_afull;
  logic             r_aempty;
  logic             r_ovf;
  logic             r_udf;
  logic             r_rvalid;
  logic             r_rd_pend;   // standard mode: memory read issued last edge
  logic             r_ovalid;    // fwft mode: output register holds the head word

  logic             w_wacc;
  logic             w_racc;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_load;
  logic             w_ovalid_nxt;
  logic             w_rptr_adv;
  logic             w_mem_re;

  assign w_wacc = i_winc & ~r_wfull;
  assign w_racc = i_rinc & ~r_rempty;

  // Occupancy update: +1 on write only, -1 on read only
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wacc && !w_racc) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (!w_wacc && w_racc) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  // FWFT prefetch: refill the output register whenever it is empty or being
  // popped and at least one word still sits in the array behind it
  always_comb begin
    w_load       = 1'b0;
    w_ovalid_nxt = 1'b0;
    w_rptr_adv   = w_racc;
    w_mem_re     = w_racc;
    if (FWFT != 0) begin
      w_load       = (~r_ovalid | w_racc) & (r_cnt != CW'(r_ovalid));
      w_ovalid_nxt = w_load | (r_ovalid & ~w_racc);
      w_rptr_adv   = w_load;
      w_mem_re     = 1'b0;
    end
  end

  // Control state: pointers, count, flags, sticky errors
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_wfull   <= 1'b0;
      r_rempty  <= 1'b1;
      r_afull   <= 1'b0;
      r_aempty  <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rd_pend <= 1'b0;
      r_ovalid  <= 1'b0;
    end else if (i_sclr) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_wfull   <= 1'b0;
      r_rempty  <= 1'b1;
      r_afull   <= 1'b0;
      r_aempty  <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rd_pend <= 1'b0;
      r_ovalid  <= 1'b0;
    end else begin
      if (w_wacc) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rptr_adv) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_cnt    <= w_cnt_nxt;
      r_wfull  <= (w_cnt_nxt == CW'(DEPTH));
      r_afull  <= (w_cnt_nxt >= CW'(AF_LVL));
      r_aempty <= (w_cnt_nxt <= CW'(AE_LVL));
      if (i_winc && r_wfull) begin
        r_ovf <= 1'b1;
      end
      if (i_rinc && r_rempty) begin
        r_udf <= 1'b1;
      end
      if (FWFT != 0) begin
        r_ovalid  <= w_ovalid_nxt;
        r_rempty  <= ~w_ovalid_nxt;
        r_rvalid  <= w_ovalid_nxt;
        r_rd_pend <= 1'b0;
      end else begin
        r_ovalid  <= 1'b0;
        r_rempty  <= (w_cnt_nxt == CW'(0));
        r_rd_pend <= w_racc;
        r_rvalid  <= r_rd_pend;
      end
    end
  end

  // Storage array: one write port, one registered read port, no reset
  always_ff @(posedge i_clk) begin
    if (w_wacc && !i_sclr) begin
      r_mem[r_wptr] <= i_wdata;
    end
    if (w_mem_re) begin
      r_mem_q <= r_mem[r_rptr];
    end
  end

  // Read data register: fwft loads the head word, standard mode forwards
  // the word fetched on the previous edge; flush leaves it untouched
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (!i_sclr) begin
      if (FWFT != 0) begin
        if (w_load) begin
          r_rdata <= r_mem[r_rptr];
        end
      end else if (r_rd_pend) begin
        r_rdata <= r_mem_q;
      end
    end
  end

  assign o_rdata        = r_rdata;
  assign o_rvalid       = r_rvalid;
  assign o_wfull        = r_wfull;
  assign o_rempty       = r_rempty;
  assign o_almost_full  = r_afull;
  assign o_almost_empty = r_aempty;
  assign o_data_cnt     = r_cnt;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_udf;

endmodule
